// File: rtl/burst_pkg.sv
// Shared definitions for the burst_buffer / burst_serializer pair:
// the two-state sequencer encoding and the word-index counter width.
package burst_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } burst_state_e;

    // Width of a counter indexing n words; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/burst_hold_stage.sv
// One-burst holding register with a valid flag. The owner raises load to
// capture a burst (only while empty) and take to release it (only while full).
module burst_hold_stage #(
    parameter int M         = 5,
    parameter int PRECISION = 5
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          load,
    input  logic [M-1:0][PRECISION-1:0]   load_data,
    input  logic                          take,
    output logic                          hold_valid,
    output logic [M-1:0][PRECISION-1:0]   hold_data
);

    // Capture on load, empty on take; load wins if both are ever seen.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (load) begin
            hold_valid <= 1'b1;
            hold_data  <= load_data;
        end else if (take) begin
            hold_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/burst_serializer.sv
// Parallel-to-serial burst converter: emits M words per accepted burst,
// index 0 first, with a one-burst hold stage so bursts stream back to back.
// Optional macro BURST_SERIALIZER_LAST_EN adds the registered out_last flag.
module burst_serializer
    import burst_pkg::*;
#(
    parameter int M         = 5,
    parameter int PRECISION = 5
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          ce,
    input  logic [M-1:0][PRECISION-1:0]   data_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [PRECISION-1:0]          data_out,
`ifdef BURST_SERIALIZER_LAST_EN
    output logic                          out_last,
`endif
    output logic                          out_valid
);

    localparam int            CW   = cnt_width(M);
    localparam logic [CW-1:0] LAST = CW'(M - 1);

    burst_state_e                 state, state_n;
    logic [CW-1:0]                cnt, cnt_n, cnt_inc;
    logic [M-1:0][PRECISION-1:0]  sh, sh_n;
    logic [PRECISION-1:0]         dout_n;
    logic                         ov_n;
    logic                         accept;
    logic                         hold_load, hold_take, hold_valid;
    logic [M-1:0][PRECISION-1:0]  hold_data;

    assign in_ready = ~hold_valid;
    assign accept   = in_valid & in_ready & ce;
    assign cnt_inc  = cnt + CW'(1);

    burst_hold_stage #(.M(M), .PRECISION(PRECISION)) u_hold (
        .clk        (clk),
        .clr        (clr),
        .load       (hold_load),
        .load_data  (data_in),
        .take       (hold_take),
        .hold_valid (hold_valid),
        .hold_data  (hold_data)
    );

    // Next-state and output selection; everything holds when ce is low.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sh_n      = sh;
        dout_n    = data_out;
        ov_n      = out_valid;
        hold_load = 1'b0;
        hold_take = 1'b0;
        if (ce) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_n = SHIFT;
                        cnt_n   = '0;
                        sh_n    = data_in;
                        dout_n  = data_in[0];
                        ov_n    = 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt != LAST) begin
                        cnt_n     = cnt_inc;
                        dout_n    = sh[cnt_inc];
                        ov_n      = 1'b1;
                        hold_load = accept;
                    end else if (hold_valid) begin
                        // Held burst takes priority; in_ready is low so no accept races it.
                        sh_n      = hold_data;
                        cnt_n     = '0;
                        dout_n    = hold_data[0];
                        ov_n      = 1'b1;
                        hold_take = 1'b1;
                    end else if (accept) begin
                        // Hold empty at the last word: load straight through, no bubble.
                        sh_n   = data_in;
                        cnt_n  = '0;
                        dout_n = data_in[0];
                        ov_n   = 1'b1;
                    end else begin
                        state_n = IDLE;
                        ov_n    = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State, counter, shift register and registered outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            cnt       <= '0;
            sh        <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sh        <= sh_n;
            data_out  <= dout_n;
            out_valid <= ov_n;
        end
    end

`ifdef BURST_SERIALIZER_LAST_EN
    // Flag the word emitted at the final index of each burst.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            out_last <= 1'b0;
        end else if (ce) begin
            out_last <= ov_n && (cnt_n == LAST);
        end
    end
`endif

endmodule

// File: tb/tb_burst_serializer.sv
// Directed self-checking bench for burst_serializer (M=5, PRECISION=5).
module tb_burst_serializer;

    localparam int M = 5;
    localparam int P = 5;
    typedef logic [M-1:0][P-1:0] burst_t;

    logic           clk = 1'b0;
    logic           clr = 1'b1;
    logic           ce = 1'b1;
    burst_t         data_in = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [P-1:0]   data_out;
    logic           out_valid;
`ifdef BURST_SERIALIZER_LAST_EN
    logic           out_last;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    burst_serializer #(.M(M), .PRECISION(P)) dut (
        .clk       (clk),
        .clr       (clr),
        .ce        (ce),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
`ifdef BURST_SERIALIZER_LAST_EN
        .out_last  (out_last),
`endif
        .out_valid (out_valid)
    );

    function automatic burst_t mk(input int w0, w1, w2, w3, w4);
        burst_t b;
        b[0] = P'(w0); b[1] = P'(w1); b[2] = P'(w2); b[3] = P'(w3); b[4] = P'(w4);
        return b;
    endfunction

    // Advance one clock; inputs settle and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; ce = 1'b1; in_valid = 1'b0; data_in = '0;
        tick(); tick();
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0 || data_out !== 5'd0 || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL reset cyc%0d: valid=%b data=%0d ready=%b, want 0 0 1",
                         i, out_valid, data_out, in_ready);
            end
        end
    endtask

    task automatic test_single();
        int exp_w[5] = '{1, 2, 3, 10, 11};
        data_in = mk(1, 2, 3, 10, 11); in_valid = 1'b1;
        tick();
        in_valid = 1'b0; data_in = '0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || data_out !== P'(exp_w[i])) begin
                n_err++;
                $display("FAIL single w%0d: valid=%b data=%0d, want 1 %0d", i, out_valid, data_out, exp_w[i]);
            end
`ifdef BURST_SERIALIZER_LAST_EN
            n_cmp++;
            if (out_last !== (i == 4)) begin
                n_err++;
                $display("FAIL single last w%0d: got %b want %b", i, out_last, (i == 4));
            end
`endif
            tick();
        end
        n_cmp++;
        if (out_valid !== 1'b0 || data_out !== 5'd11 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single idle: valid=%b data=%0d ready=%b, want 0 11 1", out_valid, data_out, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int     exp_w[15] = '{12, 13, 14, 20, 21, 22, 23, 24, 20, 21, 14, 12, 25, 23, 14};
        logic   exp_r[15] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
        burst_t a = mk(12, 13, 14, 20, 21);
        burst_t b = mk(22, 23, 24, 20, 21);
        burst_t c = mk(14, 12, 25, 23, 14);
        for (int e = 0; e < 15; e++) begin
            // Hand-scheduled offers: A at edge 0, B at edge 1 (into hold), C waits until edge 6.
            if (e == 0)      begin data_in = a; in_valid = 1'b1; end
            else if (e == 1) begin data_in = b; in_valid = 1'b1; end
            else if (e <= 6) begin data_in = c; in_valid = 1'b1; end
            else             begin data_in = '0; in_valid = 1'b0; end
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || data_out !== P'(exp_w[e]) || in_ready !== exp_r[e]) begin
                n_err++;
                $display("FAIL b2b e%0d: valid=%b data=%0d ready=%b, want 1 %0d %b",
                         e, out_valid, data_out, in_ready, exp_w[e], exp_r[e]);
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b tail: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_direct_load();
        int exp_w[10] = '{1, 2, 3, 10, 11, 4, 5, 6, 7, 8};
        for (int e = 0; e < 10; e++) begin
            // Second burst offered only on the last-word edge with hold empty.
            if (e == 0)      begin data_in = mk(1, 2, 3, 10, 11); in_valid = 1'b1; end
            else if (e == 5) begin data_in = mk(4, 5, 6, 7, 8);   in_valid = 1'b1; end
            else             begin data_in = '0; in_valid = 1'b0; end
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || data_out !== P'(exp_w[e]) || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL direct e%0d: valid=%b data=%0d ready=%b, want 1 %0d 1",
                         e, out_valid, data_out, in_ready, exp_w[e]);
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || data_out !== 5'd8) begin
            n_err++;
            $display("FAIL direct tail: valid=%b data=%0d, want 0 8", out_valid, data_out);
        end
    endtask

    task automatic test_ce();
        logic ce_pat[10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 1};
        int   exp_w[10]  = '{1, 1, 2, 2, 3, 3, 10, 10, 11, 11};
        logic exp_v[10]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        int   enabled_valid = 0;
        // ce low in IDLE must block acceptance.
        ce = 1'b0; data_in = mk(9, 9, 9, 9, 9); in_valid = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ce idle block: valid=%b want 0", out_valid);
        end
        for (int e = 0; e < 10; e++) begin
            ce = ce_pat[e];
            if (e == 0) data_in = mk(1, 2, 3, 10, 11);
            else begin data_in = '0; in_valid = 1'b0; end
            tick();
            if (ce_pat[e] && exp_v[e]) enabled_valid++;
            n_cmp++;
            if (out_valid !== exp_v[e] || (exp_v[e] && data_out !== P'(exp_w[e]))) begin
                n_err++;
                $display("FAIL ce e%0d: valid=%b data=%0d, want %b %0d", e, out_valid, data_out, exp_v[e], exp_w[e]);
            end
        end
        n_cmp++;
        if (enabled_valid != 5) begin
            n_err++;
            $display("FAIL ce count: got %0d enabled edges with valid, want 5", enabled_valid);
        end
        ce = 1'b1;
    endtask

    task automatic test_clr();
        data_in = mk(1, 2, 3, 10, 11); in_valid = 1'b1;
        tick();
        data_in = mk(4, 5, 6, 7, 8);
        tick();
        in_valid = 1'b0; data_in = '0;
        tick();
        n_cmp++;
        if (data_out !== 5'd3 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL clr setup: data=%0d ready=%b, want 3 0", data_out, in_ready);
        end
        clr = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || data_out !== 5'd0) begin
            n_err++;
            $display("FAIL clr async: valid=%b data=%0d, want 0 0", out_valid, data_out);
        end
        tick(); tick();
        clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0 || data_out !== 5'd0 || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL clr after cyc%0d: valid=%b data=%0d ready=%b, want 0 0 1",
                         i, out_valid, data_out, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_direct_load();
        test_ce();
        test_clr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
